data_memory_ctrl: RTL and testbench

Parametrised successor to the single-cycle RISC-16 data memory. Single-port synchronous RAM with a request/ready handshake, per-byte write enables, a registered read with a valid strobe, and an out-of-range address flag. After every reset, a hardware clear sequencer zeroes the whole array. Sits between the execute stage (address from `alu_out`, store data from `reg_out`) and the writeback mux (`mem_out`).

---
 rtl/data_memory_ctrl.sv | 107 ++++++++++
 tb/tb_data_memory_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Single-port synchronous data memory with req/ready handshake, byte-lane writes,
// registered read with valid strobe, sticky out-of-range flag and post-reset clear.
module data_memory_ctrl #(
  parameter  int          DATA_W = 16,
  parameter  int          ADDR_W = 8,
  localparam int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              WE_dmem,
  input  logic [BE_W-1:0]   byte_en,
  input  logic [15:0]       alu_out,
  input  logic [DATA_W-1:0] reg_out,
  output logic [DATA_W-1:0] mem_out,
  output logic              mem_valid,
  output logic              ready,
  output logic              init_done,
  output logic              addr_err
);

  localparam int            DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t            r_state;
  logic [ADDR_W:0]   r_clr_ptr;
  logic [DATA_W-1:0] r_mem_out;
  logic              r_mem_valid;
  logic              r_ready;
  logic              r_init_done;
  logic              r_addr_err;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [15:0]       w_addr_hi;
  logic              w_oor;
  logic [ADDR_W-1:0] w_idx;
  logic              w_accept;
  logic              w_wr;

  // Shift leaves zero when ADDR_W = 16, so addr_err can never set in that case.
  assign w_addr_hi = alu_out >> ADDR_W;
  assign w_oor     = |w_addr_hi;
  assign w_idx     = alu_out[ADDR_W-1:0];
  assign w_accept  = (r_state == S_IDLE) && req && r_ready;
  assign w_wr      = w_accept && WE_dmem && !w_oor;

  // Array has no reset; it is zeroed by the clear sequence instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_clr_ptr[ADDR_W-1:0]] <= '0;
      end else if (w_wr) begin
        for (int unsigned i = 0; i < BE_W; i++) begin
          if (byte_en[i]) r_mem[w_idx][8*i +: 8] <= reg_out[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_CLEAR;
      r_clr_ptr   <= '0;
      r_mem_out   <= '0;
      r_mem_valid <= 1'b0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_mem_valid <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (r_clr_ptr == LAST_PTR) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_init_done <= 1'b1;
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            if (w_oor) begin
              r_addr_err <= 1'b1;
            end else if (!WE_dmem) begin
              r_mem_out   <= r_mem[w_idx];
              r_mem_valid <= 1'b1;
            end
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  assign mem_out   = r_mem_out;
  assign mem_valid = r_mem_valid;
  assign ready     = r_ready;
  assign init_done = r_init_done;
  assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: directed vector table, hand sequences for clear/reset/
// streaming, then random traffic checked against a behavioural memory model.
module tb_data_memory_ctrl;

  localparam int DEPTH = 256;

  logic        clk;
  logic        rst;
  logic        req;
  logic        WE_dmem;
  logic [1:0]  byte_en;
  logic [15:0] alu_out;
  logic [15:0] reg_out;
  logic [15:0] mem_out;
  logic        mem_valid;
  logic        ready;
  logic        init_done;
  logic        addr_err;

  data_memory_ctrl #(.DATA_W(16), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .WE_dmem(WE_dmem), .byte_en(byte_en),
    .alu_out(alu_out), .reg_out(reg_out), .mem_out(mem_out), .mem_valid(mem_valid),
    .ready(ready), .init_done(init_done), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model: count of words cleared since reset decides readiness.
  logic [15:0] m_mem [DEPTH];
  int          m_cleared;
  logic        m_ready, m_init, m_valid, m_err;
  logic [15:0] m_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_cleared = 0; m_ready = 0; m_init = 0; m_valid = 0; m_out = '0; m_err = 0;
    end else begin
      m_valid = 0;
      if (!m_ready) begin
        m_mem[m_cleared] = '0;
        m_cleared++;
        if (m_cleared == DEPTH) begin m_ready = 1; m_init = 1; end
      end else if (req) begin
        if (int'(alu_out) >= DEPTH) m_err = 1;
        else if (WE_dmem) begin
          if (byte_en[0]) m_mem[alu_out][7:0]  = reg_out[7:0];
          if (byte_en[1]) m_mem[alu_out][15:8] = reg_out[15:8];
        end else begin
          m_out = m_mem[alu_out]; m_valid = 1;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic rq, input logic we, input logic [1:0] be,
                      input logic [15:0] a, input logic [15:0] d);
    rst = r; req = rq; WE_dmem = we; byte_en = be; alu_out = a; reg_out = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_ready", ready, m_ready);
    chk("model_init_done", init_done, m_init);
    chk("model_mem_valid", mem_valid, m_valid);
    chk("model_mem_out", mem_out, m_out);
    chk("model_addr_err", addr_err, m_err);
  endtask

  typedef struct {
    logic        req, we;
    logic [1:0]  be;
    logic [15:0] addr, data;
    logic        ev;
    logic [15:0] eo;
    logic        ee;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1, 1, 2'b11, 16'h0010, 16'hBEEF, 0, 16'h0000, 0};
    tbl[1]  = '{1, 0, 2'b00, 16'h0010, 16'h0000, 1, 16'hBEEF, 0};
    tbl[2]  = '{0, 0, 2'b00, 16'h0010, 16'h0000, 0, 16'hBEEF, 0};
    tbl[3]  = '{1, 1, 2'b11, 16'h0020, 16'h1234, 0, 16'hBEEF, 0};
    tbl[4]  = '{1, 1, 2'b01, 16'h0020, 16'hABCD, 0, 16'hBEEF, 0};
    tbl[5]  = '{1, 0, 2'b11, 16'h0020, 16'h0000, 1, 16'h12CD, 0};
    tbl[6]  = '{1, 1, 2'b00, 16'h0020, 16'hFFFF, 0, 16'h12CD, 0};
    tbl[7]  = '{1, 0, 2'b00, 16'h0020, 16'h0000, 1, 16'h12CD, 0};
    tbl[8]  = '{1, 1, 2'b11, 16'h0110, 16'h5555, 0, 16'h12CD, 1};
    tbl[9]  = '{1, 0, 2'b00, 16'h0010, 16'h0000, 1, 16'hBEEF, 1};
    tbl[10] = '{1, 0, 2'b00, 16'h0110, 16'h0000, 0, 16'hBEEF, 1};
    tbl[11] = '{1, 1, 2'b10, 16'h0030, 16'h0042, 0, 16'hBEEF, 1};
    tbl[12] = '{1, 0, 2'b00, 16'h0030, 16'h0000, 1, 16'h0000, 1};

    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    rst = 1; req = 0; WE_dmem = 0; byte_en = '0; alu_out = '0; reg_out = '0;

    // Reset, then clear with a read held pending the whole time.
    step(1, 0, 0, 2'b00, 16'h0, 16'h0);
    step(1, 0, 0, 2'b00, 16'h0, 16'h0);
    chk("rst_ready", ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_out", mem_out, 0);
    chk("rst_addr_err", addr_err, 0);
    for (int k = 1; k <= DEPTH; k++) begin
      step(0, 1, 0, 2'b00, 16'h0005, 16'h0);
      if (k == DEPTH - 1) chk("clear_ready_low_255", ready, 0);
      if (mem_valid !== 1'b0) chk("clear_no_valid", mem_valid, 0);
    end
    chk("clear_ready_256", ready, 1);
    chk("clear_init_256", init_done, 1);
    chk("clear_no_valid_256", mem_valid, 0);
    step(0, 1, 0, 2'b00, 16'h0005, 16'h0);
    chk("first_read_valid", mem_valid, 1);
    chk("first_read_out", mem_out, 16'h0000);

    // Directed table: write/read, byte lanes, out-of-range.
    foreach (tbl[i]) begin
      step(0, tbl[i].req, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].data);
      chk($sformatf("tbl%0d_valid", i), mem_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_out", i), mem_out, tbl[i].eo);
      chk($sformatf("tbl%0d_err", i), addr_err, tbl[i].ee);
    end

    // Reset mid-operation cancels an in-flight read strobe and restarts clear.
    step(0, 1, 1, 2'b11, 16'h0010, 16'hBEEF);
    step(0, 1, 0, 2'b00, 16'h0010, 16'h0);
    chk("pre_rst_valid", mem_valid, 1);
    step(1, 1, 0, 2'b00, 16'h0010, 16'h0);
    chk("midrst_ready", ready, 0);
    chk("midrst_init", init_done, 0);
    chk("midrst_err", addr_err, 0);
    chk("midrst_valid", mem_valid, 0);
    for (int k = 0; k < 100; k++) step(0, 1, 1, 2'b11, 16'h0010, 16'h1111);
    step(1, 0, 0, 2'b00, 16'h0, 16'h0);
    for (int k = 1; k <= DEPTH; k++) begin
      step(0, 0, 0, 2'b00, 16'h0, 16'h0);
      if (k == DEPTH - 1) chk("reclear_ready_low", ready, 0);
    end
    chk("reclear_ready", ready, 1);
    step(0, 1, 0, 2'b00, 16'h0010, 16'h0);
    chk("post_clear_valid", mem_valid, 1);
    chk("post_clear_out", mem_out, 16'h0000);

    // Streaming reads every cycle.
    for (int a = 0; a < 8; a++) step(0, 1, 1, 2'b11, 16'(a), 16'(a * 16'h0101));
    for (int a = 0; a < 8; a++) begin
      step(0, 1, 0, 2'b00, 16'(a), 16'h0);
      chk($sformatf("stream%0d_valid", a), mem_valid, 1);
      chk($sformatf("stream%0d_out", a), mem_out, 32'(a * 16'h0101));
    end
    step(0, 0, 0, 2'b00, 16'h0, 16'h0);
    chk("stream_end_valid", mem_valid, 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst;
      logic [15:0] r_addr;
      r_rst  = ($urandom_range(0, 399) == 0);
      r_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(256, 65535))
                                           : 16'($urandom_range(0, 15));
      step(r_rst, 1'($urandom), 1'($urandom), 2'($urandom), r_addr, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
